// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - request/result bundle between a client and bin_to_bcd_seq
interface bin_to_bcd_seq_if #(
   parameter int BIN_W = 14
);
   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   logic [3:0]       ones;
   logic [3:0]       tens;
   logic [3:0]       hundreds;
   logic [3:0]       thousands;
   logic             overflow;

   modport master (
      output start, bin,
      input  busy, done, ones, tens, hundreds, thousands, overflow
   );

   modport slave (
      input  start, bin,
      output busy, done, ones, tens, hundreds, thousands, overflow
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - one-bit-per-clock double-dabble to four BCD digits; BCD_SATURATE_EN clamps to 9999
module bin_to_bcd_seq #(
   parameter int BIN_W = 14,
   parameter int CNT_W = 4
) (
   input logic            clk,
   input logic            rst,
   bin_to_bcd_seq_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [19:0]        bcd;
   logic [BIN_W-1:0]   bin_sh;
   logic [CNT_W-1:0]   cnt;
   logic [15:0]        digits_q;
   logic               ovf_q;

   logic [19:0]        bcd_adj;
   logic [19:0]        bcd_next;
   logic [BIN_W-1:0]   bin_next;
   logic               last_iter;
   logic               ovf_next;
   logic [15:0]        digits_next;
   logic               busy_c;
   logic               done_c;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   assign bcd_next  = {bcd_adj[18:0], bin_sh[BIN_W-1]};
   assign bin_next  = {bin_sh[BIN_W-2:0], 1'b0};
   assign last_iter = (cnt == CNT_W'(BIN_W - 1));

   // A carry out of the top nibble cannot occur for legal widths, but would also mean out of range.
   assign ovf_next = (bcd_next[19:16] != 4'd0) || bcd_adj[19];

`ifdef BCD_SATURATE_EN
   assign digits_next = ovf_next ? 16'h9999 : bcd_next[15:0];
`else
   assign digits_next = bcd_next[15:0];
`endif

   always_comb begin
      state_next = state;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy_c = 1'b1;
            if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy_c     = 1'b1;
            done_c     = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Results are captured on the final shift edge so they are already valid while done is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         bcd      <= '0;
         bin_sh   <= '0;
         cnt      <= '0;
         digits_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bin_sh <= bus.bin;
                  bcd    <= '0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               bcd    <= bcd_next;
               bin_sh <= bin_next;
               cnt    <= cnt + CNT_W'(1);
               if (last_iter) begin
                  digits_q <= digits_next;
                  ovf_q    <= ovf_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.thousands = digits_q[15:12];
   assign bus.hundreds  = digits_q[11:8];
   assign bus.tens      = digits_q[7:4];
   assign bus.ones      = digits_q[3:0];
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed vector bench for bin_to_bcd_seq (honours BCD_SATURATE_EN)
module tb_bin_to_bcd_seq;
   localparam int BIN_W = 14;
   localparam int LAT   = BIN_W + 1;

   typedef struct {
      int          bin;
      logic [15:0] dig;
      logic        ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[9];

   always #5 clk = ~clk;

   bin_to_bcd_seq_if #(.BIN_W(BIN_W)) bus ();

   bin_to_bcd_seq #(.BIN_W(BIN_W), .CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [15:0] digs();
      return {bus.thousands, bus.hundreds, bus.tens, bus.ones};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_conv(input int v, output int lat);
      @(negedge clk);
      bus.bin   = v[BIN_W-1:0];
      bus.start = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.start = 1'b0;
            check("busy_after_start", int'(bus.busy), 1);
         end
         if (bus.done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int ndone;
      int done_k;
      int first_k;
      int period;

      vecs[0] = '{0,     16'h0000, 1'b0};
      vecs[1] = '{1234,  16'h1234, 1'b0};
      vecs[2] = '{9999,  16'h9999, 1'b0};
      vecs[3] = '{5,     16'h0005, 1'b0};
      vecs[4] = '{1000,  16'h1000, 1'b0};
      vecs[5] = '{8191,  16'h8191, 1'b0};
`ifdef BCD_SATURATE_EN
      vecs[6] = '{12345, 16'h9999, 1'b1};
      vecs[7] = '{16383, 16'h9999, 1'b1};
      vecs[8] = '{10000, 16'h9999, 1'b1};
`else
      vecs[6] = '{12345, 16'h2345, 1'b1};
      vecs[7] = '{16383, 16'h6383, 1'b1};
      vecs[8] = '{10000, 16'h0000, 1'b1};
`endif

      bus.start = 1'b0;
      bus.bin   = '0;
      rst       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_ovf", int'(bus.overflow), 0);
      check("reset_digits", int'(digs()), 0);

      for (int i = 0; i < 9; i++) begin
         run_conv(vecs[i].bin, lat);
         check($sformatf("latency_%0d", vecs[i].bin), lat, LAT);
         check($sformatf("digits_%0d", vecs[i].bin), int'(digs()), int'(vecs[i].dig));
         check($sformatf("ovf_%0d", vecs[i].bin), int'(bus.overflow), int'(vecs[i].ovf));
         check($sformatf("busy_at_done_%0d", vecs[i].bin), int'(bus.busy), 1);
         @(negedge clk);
         check($sformatf("done_pulse_%0d", vecs[i].bin), int'(bus.done), 0);
         check($sformatf("busy_cleared_%0d", vecs[i].bin), int'(bus.busy), 0);
         bus.bin = 14'h2aaa;
         repeat (3) @(negedge clk);
         check($sformatf("hold_%0d", vecs[i].bin), int'(digs()), int'(vecs[i].dig));
      end

      // Start pulse while busy must be dropped
      @(negedge clk);
      bus.bin   = 14'd42;
      bus.start = 1'b1;
      @(posedge clk);
      ndone  = 0;
      done_k = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
         if (k == 4) begin
            bus.start = 1'b1;
            bus.bin   = 14'd77;
         end
         if (k == 5) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            ndone++;
            if (done_k < 0) done_k = k;
         end
      end
      check("busy_start_done_count", ndone, 1);
      check("busy_start_latency", done_k, LAT);
      check("busy_start_digits", int'(digs()), 16'h0042);
      run_conv(77, lat);
      check("after_ignore_latency", lat, LAT);
      check("after_ignore_digits", int'(digs()), 16'h0077);

      // Reset in the middle of a conversion
      @(negedge clk);
      bus.bin   = 14'd5678;
      bus.start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) bus.start = 1'b0;
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("midreset_busy", int'(bus.busy), 0);
      check("midreset_digits", int'(digs()), 0);
      check("midreset_ovf", int'(bus.overflow), 0);
      ndone = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      check("midreset_no_done", ndone, 0);
      run_conv(5678, lat);
      check("restart_latency", lat, LAT);
      check("restart_digits", int'(digs()), 16'h5678);

      // Start held high: back-to-back conversions
      @(negedge clk);
      bus.bin   = 14'd1234;
      bus.start = 1'b1;
      @(posedge clk);
      first_k = -1;
      period  = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (first_k < 0) begin
               first_k = k;
            end else begin
               period = k - first_k;
               break;
            end
         end
      end
      bus.start = 1'b0;
      check("b2b_first_latency", first_k, LAT);
      check("b2b_period", period, BIN_W + 2);
      check("b2b_digits", int'(digs()), 16'h1234);
      repeat (20) @(negedge clk);
      check("b2b_idle", int'(bus.busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
